// File: rtl/i2c_master.sv
// i2c_master: single-master I2C register write / register read engine.
// Every bit is four DIVIDER-cycle phases: SCL low, low, high, high. SDA moves
// at the start of phase 0 (START/RESTART/STOP move it in phase 3) and is
// sampled at the end of phase 2.
// Optional feature macro: I2C_CLK_STRETCH_EN. When defined, the phase divider
// freezes while SCL is released but still reads low (slave clock stretching).
// When undefined, scl_i is ignored and bit timing is fixed.
`timescale 1ns/1ps
module i2c_master #(
  parameter int I2C_DATA_WIDTH = 8,
  parameter int REGISTER_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 7,
  parameter int DIVIDER        = 64
) (
  input  logic                      pclk,
  input  logic                      vb_rst_n,
  input  logic                      i2c_enable,
  input  logic                      i2c_read_write,
  input  logic [I2C_DATA_WIDTH-1:0] i2c_mosi_data,
  input  logic [REGISTER_WIDTH-1:0] i2c_register_address,
  input  logic [ADDRESS_WIDTH-1:0]  i2c_device_address,
  output logic                      i2c_busy,
  output logic [I2C_DATA_WIDTH-1:0] i2c_miso_data,
  output logic                      i2c_ack_error,
  output logic                      scl_oe,
  output logic                      sda_oe,
  input  logic                      scl_i,
  input  logic                      sda_i
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND_BYTE,
    SLAVE_ACK,
    RESTART,
    RECV_BYTE,
    MASTER_NACK,
    STOP
  } state_e;

  localparam logic [9:0] DIV_LAST = 10'(DIVIDER - 1);

  state_e                    state_q, state_d;
  logic [9:0]                div_q, div_d;
  logic [1:0]                phase_q, phase_d;
  logic [2:0]                bit_q, bit_d;
  logic [1:0]                byte_q, byte_d;
  logic [7:0]                tx_q, tx_d;
  logic [7:0]                rx_q, rx_d;
  logic                      rw_q, rw_d;
  logic [I2C_DATA_WIDTH-1:0] data_q, data_d;
  logic [REGISTER_WIDTH-1:0] reg_q, reg_d;
  logic [ADDRESS_WIDTH-1:0]  dev_q, dev_d;
  logic [I2C_DATA_WIDTH-1:0] miso_q, miso_d;
  logic                      ack_err_q, ack_err_d;
  logic                      busy_q, busy_d;
  logic                      scl_oe_q, scl_oe_d;
  logic                      sda_oe_q, sda_oe_d;

  logic hold;
  logic phase_end;
  logic sample_pt;
  logic bit_end;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low during the released half of a bit freezes timing.
  assign hold = (state_q != IDLE) && phase_q[1] && !scl_i;
`else
  logic scl_unused;
  assign hold       = 1'b0;
  assign scl_unused = scl_i;
`endif

  assign phase_end = (div_q == DIV_LAST) && !hold;
  assign sample_pt = phase_end && (phase_q == 2'd2);
  assign bit_end   = phase_end && (phase_q == 2'd3);

  // Next-state logic: request capture, bit timing and the byte sequencing.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rw_d      = rw_q;
    data_d    = data_q;
    reg_d     = reg_q;
    dev_d     = dev_q;
    miso_d    = miso_q;
    ack_err_d = ack_err_q;

    if (state_q != IDLE) begin
      if (!hold) begin
        div_d = phase_end ? 10'd0 : div_q + 10'd1;
      end
      if (phase_end) begin
        phase_d = phase_q + 2'd1;
      end
    end

    case (state_q)
      IDLE: begin
        div_d   = 10'd0;
        phase_d = 2'd0;
        bit_d   = 3'd0;
        byte_d  = 2'd0;
        if (i2c_enable) begin
          rw_d      = i2c_read_write;
          data_d    = i2c_mosi_data;
          reg_d     = i2c_register_address;
          dev_d     = i2c_device_address;
          ack_err_d = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = {7'(dev_q), 1'b0};
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          state_d = SEND_BYTE;
        end
      end
      RESTART: begin
        if (bit_end) begin
          tx_d    = {7'(dev_q), 1'b1};
          bit_d   = 3'd0;
          byte_d  = 2'd2;
          state_d = SEND_BYTE;
        end
      end
      SEND_BYTE: begin
        if (bit_end) begin
          tx_d  = {tx_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = SLAVE_ACK;
          end
        end
      end
      SLAVE_ACK: begin
        if (sample_pt && sda_i) begin
          ack_err_d = 1'b1;
        end
        if (bit_end) begin
          if (ack_err_q) begin
            state_d = STOP;
          end else begin
            case (byte_q)
              2'd0: begin
                tx_d    = 8'(reg_q);
                byte_d  = 2'd1;
                state_d = SEND_BYTE;
              end
              2'd1: begin
                if (rw_q) begin
                  state_d = RESTART;
                end else begin
                  tx_d    = 8'(data_q);
                  byte_d  = 2'd2;
                  state_d = SEND_BYTE;
                end
              end
              default: begin
                state_d = rw_q ? RECV_BYTE : STOP;
              end
            endcase
          end
        end
      end
      RECV_BYTE: begin
        if (sample_pt) begin
          rx_d = {rx_q[6:0], sda_i};
        end
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            miso_d  = I2C_DATA_WIDTH'(rx_q);
            state_d = MASTER_NACK;
          end
        end
      end
      MASTER_NACK: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line drive for the upcoming cycle, so the pins come straight from flops.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_d)
      IDLE: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
      START, RESTART: begin
        scl_oe_d = ~phase_d[1];
        sda_oe_d = (phase_d == 2'd3);
      end
      STOP: begin
        scl_oe_d = ~phase_d[1];
        sda_oe_d = (phase_d != 2'd3);
      end
      SEND_BYTE: begin
        scl_oe_d = ~phase_d[1];
        sda_oe_d = ~tx_d[7];
      end
      default: begin
        scl_oe_d = ~phase_d[1];
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops both lines with no STOP.
  always_ff @(posedge pclk) begin
    if (!vb_rst_n) begin
      state_q   <= IDLE;
      div_q     <= 10'd0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      tx_q      <= 8'd0;
      rx_q      <= 8'd0;
      rw_q      <= 1'b0;
      data_q    <= '0;
      reg_q     <= '0;
      dev_q     <= '0;
      miso_q    <= '0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rw_q      <= rw_d;
      data_q    <= data_d;
      reg_q     <= reg_d;
      dev_q     <= dev_d;
      miso_q    <= miso_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign i2c_busy      = busy_q;
  assign i2c_miso_data = miso_q;
  assign i2c_ack_error = ack_err_q;
  assign scl_oe        = scl_oe_q;
  assign sda_oe        = sda_oe_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: drives i2c_master (DIVIDER=4) against a behavioural I2C
// slave on a wired-AND bus, and compares decoded bus traffic, busy length
// and status outputs with a transaction-level reference model.
`timescale 1ns/1ps
module tb_i2c_master;

  localparam int DIV       = 4;
  localparam int TOK_START = 1000;
  localparam int TOK_STOP  = 1001;
`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH_VISIBLE = 1'b1;
  localparam int STRETCH_EXTRA   = 100;
`else
  localparam bit STRETCH_VISIBLE = 1'b0;
  localparam int STRETCH_EXTRA   = 0;
`endif

  logic       pclk = 1'b0;
  logic       vbRstN = 1'b0;
  logic       enable = 1'b0;
  logic       readWrite = 1'b0;
  logic [7:0] mosiData = 8'd0;
  logic [7:0] regAddr = 8'd0;
  logic [6:0] devAddr = 7'd0;
  logic       busy;
  logic [7:0] misoData;
  logic       ackError;
  logic       sclOe;
  logic       sdaOe;
  logic       sclLine;
  logic       sdaLine;

  logic       slaveSdaLow = 1'b0;
  logic       stretchLow = 1'b0;
  bit         stretchArm = 1'b0;
  int         releaseCnt = 0;

  int         errors = 0;
  int         checks = 0;
  int         busyCnt = 0;
  int         tokens[$];
  int         expTokens[$];
  logic [7:0] expMiso = 8'd0;

  bit         active = 1'b0;
  bit         isRead = 1'b0;
  int         slot = -1;
  int         frame = 0;
  logic [7:0] shiftByte = 8'd0;
  logic [7:0] slaveByte = 8'd0;
  bit         slaveNackAddr = 1'b0;
  bit         prevScl = 1'b1;
  bit         prevSda = 1'b1;

  assign sclLine = !sclOe && !stretchLow;
  assign sdaLine = !sdaOe && !slaveSdaLow;

  i2c_master #(
    .I2C_DATA_WIDTH(8),
    .REGISTER_WIDTH(8),
    .ADDRESS_WIDTH(7),
    .DIVIDER(DIV)
  ) dut (
    .pclk(pclk),
    .vb_rst_n(vbRstN),
    .i2c_enable(enable),
    .i2c_read_write(readWrite),
    .i2c_mosi_data(mosiData),
    .i2c_register_address(regAddr),
    .i2c_device_address(devAddr),
    .i2c_busy(busy),
    .i2c_miso_data(misoData),
    .i2c_ack_error(ackError),
    .scl_oe(sclOe),
    .sda_oe(sdaOe),
    .scl_i(sclLine),
    .sda_i(sdaLine)
  );

  always #5 pclk = ~pclk;

  // Count every cycle the master reports busy.
  always @(posedge pclk) begin
    #1;
    if (busy === 1'b1) busyCnt++;
  end

  // Behavioural slave: decodes START/STOP/bytes and answers ACKs and read data.
  always @(negedge pclk) begin
    bit curScl;
    bit curSda;
    curScl = !sclOe && !(stretchLow && STRETCH_VISIBLE);
    curSda = !sdaOe && !slaveSdaLow;
    if (prevScl && curScl && prevSda && !curSda) begin
      tokens.push_back(TOK_START);
      active = 1'b1;
      slot = -1;
      frame = 0;
      isRead = 1'b0;
      slaveSdaLow = 1'b0;
    end else if (prevScl && curScl && !prevSda && curSda) begin
      tokens.push_back(TOK_STOP);
      active = 1'b0;
      slaveSdaLow = 1'b0;
    end else if (active && !prevScl && curScl) begin
      if (slot >= 0 && slot < 8) begin
        shiftByte = {shiftByte[6:0], curSda};
      end else if (slot == 8) begin
        tokens.push_back(int'({shiftByte, curSda}));
        if (frame == 0) isRead = shiftByte[0];
      end
    end else if (active && prevScl && !curScl) begin
      slot++;
      if (slot == 9) begin
        slot = 0;
        frame++;
      end
      slaveSdaLow = 1'b0;
      if (isRead && frame == 1 && slot < 8) begin
        slaveSdaLow = !slaveByte[7 - slot];
      end else if (slot == 8 && !(isRead && frame == 1) && !(slaveNackAddr && frame == 0)) begin
        slaveSdaLow = 1'b1;
      end
    end
    prevScl = curScl;
    prevSda = !sdaOe && !slaveSdaLow;
  end

  // Slave clock stretch: hold SCL low 100 cycles once the 10th release appears.
  initial begin
    bit prevOe = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      if (stretchArm && prevOe && !sclOe) begin
        releaseCnt++;
        if (releaseCnt == 10) begin
          stretchLow = 1'b1;
          repeat (100) @(posedge pclk);
          #1 stretchLow = 1'b0;
          stretchArm = 1'b0;
        end
      end
      prevOe = sclOe;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: bus tokens of one transaction, frames as {byte, ackbit}.
  function automatic void expectTxn(input bit rd, input logic [6:0] dev, input logic [7:0] regA,
                                    input logic [7:0] data, input logic [7:0] rdByte, input bit nack);
    expTokens.push_back(TOK_START);
    if (nack) begin
      expTokens.push_back(int'(dev) * 4 + 1);
      expTokens.push_back(TOK_STOP);
      return;
    end
    expTokens.push_back(int'(dev) * 4);
    expTokens.push_back(int'(regA) * 2);
    if (rd) begin
      expTokens.push_back(TOK_START);
      expTokens.push_back(int'(dev) * 4 + 2);
      expTokens.push_back(int'(rdByte) * 2 + 1);
    end else begin
      expTokens.push_back(int'(data) * 2);
    end
    expTokens.push_back(TOK_STOP);
  endfunction

  // Bit times = START + 9 per byte frame + RESTART (reads) + STOP.
  function automatic int expBusy(input bit rd, input bit nack);
    int frames;
    frames = nack ? 1 : (rd ? 4 : 3);
    return (frames * 9 + 2 + ((rd && !nack) ? 1 : 0)) * 4 * DIV;
  endfunction

  task automatic checkTokens(input string tag);
    checkOutput({tag, "_tokcount"}, tokens.size(), expTokens.size());
    for (int i = 0; i < expTokens.size() && i < tokens.size(); i++) begin
      checkOutput($sformatf("%s_tok%0d", tag, i), tokens[i], expTokens[i]);
    end
    tokens.delete();
    expTokens.delete();
  endtask

  task automatic applyStimulus(input bit rd, input logic [6:0] dev, input logic [7:0] regA,
                               input logic [7:0] data, input string tag);
    readWrite = rd;
    devAddr = dev;
    regAddr = regA;
    mosiData = data;
    busyCnt = 0;
    enable = 1'b1;
    @(negedge pclk);
    enable = 1'b0;
    checkOutput({tag, "_busyrise"}, busy, 1'b1);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    checkOutput({tag, "_timeout"}, n < 3000, 1'b1);
  endtask

  task automatic runTxn(input bit rd, input logic [6:0] dev, input logic [7:0] regA, input logic [7:0] data,
                        input logic [7:0] rdByte, input bit nack, input string tag);
    slaveByte = rdByte;
    slaveNackAddr = nack;
    expectTxn(rd, dev, regA, data, rdByte, nack);
    applyStimulus(rd, dev, regA, data, tag);
    waitIdle(tag);
    checkTokens(tag);
    checkOutput({tag, "_busylen"}, busyCnt, expBusy(rd, nack));
    checkOutput({tag, "_ackerr"}, ackError, nack);
    if (rd && !nack) expMiso = rdByte;
    checkOutput({tag, "_miso"}, misoData, expMiso);
    slaveNackAddr = 1'b0;
    @(negedge pclk);
  endtask

  initial begin
    int gap;
    // Reset state.
    repeat (3) @(negedge pclk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_scl", sclOe, 1'b0);
    checkOutput("rst_sda", sdaOe, 1'b0);
    checkOutput("rst_ackerr", ackError, 1'b0);
    checkOutput("rst_miso", misoData, 8'h00);
    vbRstN = 1'b1;
    repeat (2) @(negedge pclk);

    // Directed write; inputs and enable toggled mid-transaction must be ignored.
    $display("[TB] directed write");
    slaveByte = 8'h00;
    expectTxn(1'b0, 7'h18, 8'h0B, 8'h81, 8'h00, 1'b0);
    applyStimulus(1'b0, 7'h18, 8'h0B, 8'h81, "wr");
    repeat (5) @(negedge pclk);
    mosiData = 8'hFF;
    devAddr = 7'h55;
    regAddr = 8'h77;
    readWrite = 1'b1;
    enable = 1'b1;
    repeat (20) @(negedge pclk);
    enable = 1'b0;
    waitIdle("wr");
    checkTokens("wr");
    checkOutput("wr_busylen", busyCnt, 464);
    checkOutput("wr_ackerr", ackError, 1'b0);
    checkOutput("wr_miso", misoData, 8'h00);
    @(negedge pclk);

    // Directed read and address NACK.
    $display("[TB] directed read and nack");
    runTxn(1'b1, 7'h18, 8'h00, 8'h00, 8'hA5, 1'b0, "rd");
    checkOutput("rd_len624", busyCnt, 624);
    runTxn(1'b0, 7'h19, 8'h0B, 8'h81, 8'h00, 1'b1, "nack");
    checkOutput("nack_len176", busyCnt, 176);

    // Reset during data byte bit 3 of a write: lines drop, no STOP on the bus.
    $display("[TB] reset mid-transaction");
    applyStimulus(1'b0, 7'h18, 8'h0B, 8'h81, "mr");
    repeat (357) @(negedge pclk);
    checkOutput("mr_prebusy", busy, 1'b1);
    checkOutput("mr_prescl", sclOe, 1'b1);
    vbRstN = 1'b0;
    @(negedge pclk);
    vbRstN = 1'b1;
    checkOutput("mr_busy", busy, 1'b0);
    checkOutput("mr_scl", sclOe, 1'b0);
    checkOutput("mr_sda", sdaOe, 1'b0);
    checkOutput("mr_miso", misoData, 8'h00);
    expMiso = 8'h00;
    active = 1'b0;
    slaveSdaLow = 1'b0;
    repeat (4) @(negedge pclk);
    expTokens.push_back(TOK_START);
    expTokens.push_back(int'(7'h18) * 4);
    expTokens.push_back(int'(8'h0B) * 2);
    checkTokens("mr");
    runTxn(1'b0, 7'h18, 8'h0B, 8'h81, 8'h00, 1'b0, "mrafter");

    // Slave stretches SCL during the first ACK.
    $display("[TB] clock stretch");
    releaseCnt = 0;
    stretchArm = 1'b1;
    expectTxn(1'b0, 7'h18, 8'h0B, 8'h81, 8'h00, 1'b0);
    applyStimulus(1'b0, 7'h18, 8'h0B, 8'h81, "st");
    waitIdle("st");
    checkTokens("st");
    checkOutput("st_busylen", busyCnt, 464 + STRETCH_EXTRA);
    checkOutput("st_ackerr", ackError, 1'b0);
    stretchArm = 1'b0;
    @(negedge pclk);

    // Back-to-back writes with enable held high.
    $display("[TB] back-to-back");
    expectTxn(1'b0, 7'h2A, 8'h10, 8'h3C, 8'h00, 1'b0);
    expectTxn(1'b0, 7'h2A, 8'h10, 8'hC3, 8'h00, 1'b0);
    readWrite = 1'b0;
    devAddr = 7'h2A;
    regAddr = 8'h10;
    mosiData = 8'h3C;
    busyCnt = 0;
    enable = 1'b1;
    @(negedge pclk);
    mosiData = 8'hC3;
    waitIdle("b2b1");
    gap = 0;
    while (busy !== 1'b1 && gap < 10) begin
      gap++;
      @(negedge pclk);
    end
    enable = 1'b0;
    checkOutput("b2b_gap", gap, 1);
    waitIdle("b2b2");
    checkTokens("b2b");
    checkOutput("b2b_busylen", busyCnt, 928);
    @(negedge pclk);

    // Randomized transactions against the reference model.
    $display("[TB] random transactions");
    for (int k = 0; k < 6; k++) begin
      runTxn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
